// File: rtl/dual_port_pkg.sv
// dual_port_pkg: shared sizing and types for the dual_port RAM.
//   DATA_WIDTH - default word width
//   ADDR_WIDTH - default address width
//   DEPTH      - number of words, always 2**ADDR_WIDTH
//   word_t     - one data word at the default width
//   addr_t     - one address at the default width
package dual_port_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/dual_port_mem_array.sv
// dual_port_mem_array: storage array with synchronous write and synchronous clear.
// The read side is an asynchronous lookup; the top registers it.
//   clk        - clock, all updates on the rising edge
//   reset      - synchronous active-high clear of every word
//   we_i       - write enable
//   add_wr_i   - write address
//   data_in_i  - write data
//   rd_addr_i  - lookup address
//   rd_data_o  - current contents of mem[rd_addr_i]
module dual_port_mem_array
    import dual_port_pkg::*;
#(
    parameter int DATA_WIDTH = dual_port_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dual_port_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] add_wr_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the whole array is cleared on reset because reads after reset must
    // return zero; this forces flip-flop storage instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking so every state element updates from pre-edge values.
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[add_wr_i] <= data_in_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dual_port.sv
// dual_port: single-clock simple dual-port RAM with a registered read port.
// Write-first on a same-address read/write; data_out holds while re is low.
//   clk      - clock, all updates on the rising edge
//   reset    - synchronous active-high; clears memory and data_out
//   data_in  - write data
//   we       - write enable
//   add_wr   - write address
//   re       - read enable
//   read_wr  - read address
//   data_out - registered read data
module dual_port
    import dual_port_pkg::*;
#(
    parameter int DATA_WIDTH = dual_port_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dual_port_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] add_wr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_wr,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;

    dual_port_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .we_i      (we),
        .add_wr_i  (add_wr),
        .data_in_i (data_in),
        .rd_addr_i (read_wr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        // NOTE: default first so no path leaves data_out_d unassigned (no latch).
        data_out_d = data_out_q;
        if (re) begin
            // Same-address collision returns the word being written this cycle.
            if (we && (add_wr == read_wr)) begin
                data_out_d = data_in;
            end else begin
                data_out_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_dual_port.sv
// tb_dual_port: directed test-plan sequences plus randomized traffic, all
// compared against an array-based reference model of the RAM.
module tb_dual_port;
    import dual_port_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        we;
    logic [7:0]  add_wr;
    logic        re;
    logic [7:0]  read_wr;
    logic [7:0]  data_out;

    dual_port dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .we       (we),
        .add_wr   (add_wr),
        .re       (re),
        .read_wr  (read_wr),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array plus the last value presented on data_out.
    logic [7:0] model_mem [256];
    logic [7:0] model_out;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle (called just after a falling edge), let the rising edge
    // happen, update the model, then compare on the next falling edge.
    task automatic step(input bit rs, input bit w, input logic [7:0] aw,
                        input logic [7:0] d, input bit r, input logic [7:0] ra);
        reset   = rs;
        we      = w;
        add_wr  = aw;
        data_in = d;
        re      = r;
        read_wr = ra;
        @(posedge clk);
        if (rs) begin
            foreach (model_mem[i]) model_mem[i] = 8'h00;
            model_out = 8'h00;
        end else begin
            if (r) model_out = (w && aw == ra) ? d : model_mem[ra];
            if (w) model_mem[aw] = d;
        end
        @(negedge clk);
        check("model", data_out, model_out);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        model_out = 8'h00;
        reset = 1'b1; we = 1'b0; re = 1'b0;
        add_wr = '0; read_wr = '0; data_in = '0;
        @(negedge clk);

        // Power-up reset.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        check("reset_out", data_out, 8'h00);

        // Reset discards earlier write; a write in the reset cycle is also dropped.
        step(1'b0, 1'b1, 8'd3, 8'hAA, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'd4, 8'hBB, 1'b1, 8'd3);
        check("reset_out_after", data_out, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd3);
        check("reset_rd3", data_out, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd4);
        check("reset_rd4", data_out, 8'h00);

        // Sequential write then read.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 8'(i), 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i));
            check("seq_rd", data_out, 8'(i));
        end

        // Same-address collision is write-first.
        step(1'b0, 1'b1, 8'd5, 8'h11, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'd5, 8'h22, 1'b1, 8'd5);
        check("collide_out", data_out, 8'h22);
        idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd5);
        check("collide_mem", data_out, 8'h22);

        // Different addresses in the same cycle are independent.
        step(1'b0, 1'b1, 8'd7, 8'h33, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'd8, 8'h44, 1'b1, 8'd7);
        check("diff_old", data_out, 8'h33);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd8);
        check("diff_new", data_out, 8'h44);

        // Hold while re is low, with writes elsewhere and X on data_in when we=0.
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1);
        check("hold_rd1", data_out, 8'h01);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'(100 + i), 8'hC0, 1'b0, 8'd1);
            check("hold", data_out, 8'h01);
        end
        step(1'b0, 1'b0, 8'd1, 8'hxx, 1'b0, 8'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1);
        check("x_no_corrupt", data_out, 8'h01);

        // Boundary addresses, no aliasing between 0 and 255.
        step(1'b0, 1'b1, 8'd255, 8'hFF, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'd0,   8'h5A, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00,  8'h00, 1'b1, 8'd255);
        check("bound_255", data_out, 8'hFF);
        step(1'b0, 1'b0, 8'h00,  8'h00, 1'b1, 8'd0);
        check("bound_0", data_out, 8'h5A);

        // Randomized traffic; small address window half the time to force collisions.
        for (int n = 0; n < 3000; n++) begin
            bit         rs, w, r;
            logic [7:0] aw, ra, d;
            rs = ($urandom_range(0, 199) == 0);
            w  = $urandom_range(0, 1);
            r  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 0) begin
                aw = 8'($urandom_range(0, 7));
                ra = 8'($urandom_range(0, 7));
            end else begin
                aw = 8'($urandom);
                ra = 8'($urandom);
            end
            d = 8'($urandom);
            if (!w && $urandom_range(0, 3) == 0) d = 8'hxx;
            step(rs, w, aw, d, r, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
